// File: rtl/multiplier_iterative_unit.sv
// ---------------------------------------------------------------------------
// multiplier_iterative_unit
//
// Sequential unsigned 32x32 -> 64-bit multiplier. It uses a shift-and-add
// datapath that resolves one multiplier bit per clock. A one-cycle valid_in
// pulse in IDLE starts an operation. Exactly 32 clocks later the product
// appears on r, together with a one-cycle valid_out pulse.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high; forces IDLE and clears all outputs
//   valid_in   start request, sampled only while IDLE
//   a          32-bit unsigned multiplicand, captured on start
//   b          32-bit unsigned multiplier, captured on start
//   valid_out  one-cycle pulse marking a freshly completed product on r
//   r          64-bit product of the last completed operation (held)
// ---------------------------------------------------------------------------
module multiplier_iterative_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        valid_out,
  output logic [63:0] r
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [63:0] mcand;
  logic [31:0] mplier;
  logic [63:0] acc;
  logic [5:0]  count;

  logic [63:0] sum_next;
  logic        last_iter;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The accumulator value after this cycle's iteration. The same value feeds
  // r on the final iteration, so the last partial product is included in r.
  // The FSM stays in BUSY for exactly 32 iterations and has no early exit.
  always_comb begin
    sum_next   = acc + (mplier[0] ? mcand : 64'd0);
    last_iter  = (count == 6'd31);
    state_next = state;
    case (state)
      IDLE: if (valid_in)  state_next = BUSY;
      BUSY: if (last_iter) state_next = IDLE;
      default:             state_next = IDLE;
    endcase
  end

  // Datapath and output registers. valid_out defaults low so that it is a
  // single-cycle pulse. r is written only on completion, so it keeps the
  // previous product while a new operation runs. Requests that arrive in
  // BUSY are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand     <= 64'd0;
      mplier    <= 32'd0;
      acc       <= 64'd0;
      count     <= 6'd0;
      r         <= 64'd0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in) begin
            mcand  <= {32'd0, a};
            mplier <= b;
            acc    <= 64'd0;
            count  <= 6'd0;
          end
        end
        BUSY: begin
          acc    <= sum_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 6'd1;
          if (last_iter) begin
            r         <= sum_next;
            valid_out <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier_iterative_unit.sv
// ---------------------------------------------------------------------------
// tb_multiplier_iterative_unit
//
// Self-checking bench for multiplier_iterative_unit. Expected products come
// from plain 64-bit multiplication of the operands. Latency and
// pulse-width expectations come from the documented timing: 32 cycles from
// the accepting edge to valid_out, and a one-cycle pulse.
// ---------------------------------------------------------------------------
module tb_multiplier_iterative_unit;

  logic        clk;
  logic        reset;
  logic        valid_in;
  logic [31:0] a;
  logic [31:0] b;
  logic        valid_out;
  logic [63:0] r;

  int errors = 0;
  int checks = 0;

  // Reference for what r should currently hold.
  logic [63:0] model_r = 64'd0;

  multiplier_iterative_unit dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .a         (a),
    .b         (b),
    .valid_out (valid_out),
    .r         (r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] wx;
    logic [63:0] wy;
    wx = {32'd0, x};
    wy = {32'd0, y};
    return wx * wy;
  endfunction

  // Present a start request for one clock. The request is accepted at the
  // next rising edge. After capture, the operands are scrambled so that any
  // late sampling of a/b corrupts the result.
  task automatic start_op(input logic [31:0] x, input logic [31:0] y);
    valid_in = 1'b1;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  // Step one edge at a time until valid_out is seen or the budget runs out.
  // Reports the edge count (0 on timeout) and whether r moved beforehand.
  task automatic wait_done(input logic [63:0] hold_val, output int lat, output bit stable);
    lat = 0;
    stable = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (valid_out) begin
        lat = n;
        break;
      end
      if (r !== hold_val) stable = 1'b0;
    end
  endtask

  // Runs one complete operation and checks the product, the latency, r
  // stability and the pulse width.
  task automatic run_and_check(input string tag, input logic [31:0] x, input logic [31:0] y);
    int          lat;
    bit          stable;
    logic [63:0] expected;
    expected = ref_mul(x, y);
    start_op(x, y);
    wait_done(model_r, lat, stable);
    checks++;
    if (lat !== 32) begin
      errors++;
      $display("[TB] FAIL %s latency a=%h b=%h: got %0d required 32", tag, x, y, lat);
    end
    checks++;
    if (r !== expected) begin
      errors++;
      $display("[TB] FAIL %s product a=%h b=%h: got %h required %h", tag, x, y, r, expected);
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("[TB] FAIL %s r_stability: got r changed before pulse, required hold %h", tag, model_r);
    end
    model_r = expected;
    @(posedge clk);
    #1;
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s pulse_width: got valid_out=%b required 0", tag, valid_out);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    valid_in = 1'b0;
    a = 32'd0;
    b = 32'd0;
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (valid_out !== 1'b0 || r !== 64'd0) begin
      errors++;
      $display("[TB] FAIL reset_values: got valid_out=%b r=%h required 0 and 0", valid_out, r);
    end
    @(posedge clk);
    #1;
    run_and_check("reset_first_op", 32'd3, 32'd5);
    // Assert reset asynchronously, between edges, while r holds 15.
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (valid_out !== 1'b0 || r !== 64'd0) begin
      errors++;
      $display("[TB] FAIL async_reset: got valid_out=%b r=%h required 0 and 0", valid_out, r);
    end
    model_r = 64'd0;
    @(posedge clk);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 100; i++) begin
      run_and_check("sweep", i, i);
    end
  endtask

  task automatic test_extremes();
    logic [31:0] xa [3] = '{32'hFFFFFFFF, 32'h80000000, 32'h00000000};
    logic [31:0] xb [3] = '{32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF};
    logic [63:0] xr [3] = '{64'hFFFFFFFE00000001, 64'h0000000100000000, 64'h0};
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ref_mul(xa[i], xb[i]) !== xr[i]) begin
        errors++;
        $display("[TB] FAIL extreme_model %0d: got %h required %h", i, ref_mul(xa[i], xb[i]), xr[i]);
      end
      run_and_check("extreme", xa[i], xb[i]);
    end
  endtask

  task automatic test_random();
    logic [31:0] ra;
    logic [31:0] rb;
    ra = 32'd0;
    rb = 32'd0;
    for (int i = 0; i < 100; i++) begin
      run_and_check("stepped", ra, rb);
      ra = ra + 32'h23456789;
      rb = rb + 32'h34567891;
    end
    for (int i = 0; i < 40; i++) begin
      run_and_check("random", $urandom, $urandom);
    end
  endtask

  task automatic test_busy_ignore();
    int pulses;
    int first_at;
    pulses = 0;
    first_at = 0;
    start_op(32'd7, 32'd6);
    for (int n = 1; n <= 80; n++) begin
      if (n == 10) begin
        valid_in = 1'b1;
        a = 32'd9;
        b = 32'd9;
      end
      @(posedge clk);
      #1;
      if (n == 10) valid_in = 1'b0;
      if (valid_out) begin
        pulses++;
        if (first_at == 0) begin
          first_at = n;
          checks++;
          if (r !== 64'd42) begin
            errors++;
            $display("[TB] FAIL busy_ignore_product: got %h required %h", r, 64'd42);
          end
        end
      end
    end
    model_r = 64'd42;
    checks++;
    if (first_at !== 32 || pulses !== 1) begin
      errors++;
      $display("[TB] FAIL busy_ignore_pulses: got %0d pulses first at %0d required 1 at 32", pulses, first_at);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    start_op(32'h00001234, 32'h00005678);
    repeat (15) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (r !== 64'd0 || valid_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_values: got r=%h valid_out=%b required 0 and 0", r, valid_out);
    end
    model_r = 64'd0;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (valid_out) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("[TB] FAIL reset_mid_no_pulse: got %0d pulses required 0", pulses);
    end
    run_and_check("after_reset", 32'd2, 32'd21);
  endtask

  task automatic test_back_to_back();
    int          lat;
    bit          stable;
    logic [63:0] exp1;
    logic [63:0] exp2;
    exp1 = ref_mul(32'd11, 32'd13);
    exp2 = ref_mul(32'd17, 32'd19);
    // Hold valid_in high. The second operation must start in the
    // valid_out cycle.
    valid_in = 1'b1;
    a = 32'd11;
    b = 32'd13;
    @(posedge clk);
    #1;
    wait_done(model_r, lat, stable);
    checks++;
    if (lat !== 32 || r !== exp1) begin
      errors++;
      $display("[TB] FAIL b2b_first: got lat=%0d r=%h required 32 and %h", lat, r, exp1);
    end
    model_r = exp1;
    a = 32'd17;
    b = 32'd19;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    wait_done(model_r, lat, stable);
    checks++;
    if (lat !== 32 || r !== exp2 || !stable) begin
      errors++;
      $display("[TB] FAIL b2b_second: got lat=%0d r=%h stable=%b required 32 and %h stable", lat, r, stable, exp2);
    end
    model_r = exp2;
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_extremes();
    test_random();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
